fetch_prefetch: RTL and testbench

Next-generation fetch stage. It decouples instruction-memory latency from the decode stage with a parametrised prefetch FIFO, so a slow or bursty i_read_ack no longer bubbles the pipeline. The block sits between instruction memory (req/ack handshake) and decode. It handles jump and interrupt redirects by flushing the buffer, and reports refill stalls to the hazard unit.

---
 rtl/fetch_prefetch_if.sv | 35 +++
 rtl/fetch_prefetch.sv | 135 +++++++++++++
 tb/tb_fetch_prefetch.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_if.sv
// Bundle of the fetch stage's memory handshake, redirect, control and decode-side signals.
// The slave modport is the fetch stage's view of the bundle; the master modport is the environment's view.
interface fetch_prefetch_if #(
  parameter int PC_WIDTH    = 30,
  parameter int INSTR_WIDTH = 32,
  parameter int LVL_WIDTH   = 3
);
  logic                   i_core_en;
  logic                   i_stall;
  logic                   i_jmp_en;
  logic                   i_ie_catch;
  logic [PC_WIDTH-1:0]    i_pc_jmp;
  logic                   o_read_req;
  logic [PC_WIDTH-1:0]    o_read_addr;
  logic                   i_read_ack;
  logic [INSTR_WIDTH-1:0] i_instr_mem;
  logic [INSTR_WIDTH-1:0] o_instruction;
  logic [PC_WIDTH-1:0]    o_pc_fe;
  logic [PC_WIDTH-1:0]    o_inc_pc;
  logic                   o_valid;
  logic                   o_stall_en_fe;
  logic [LVL_WIDTH-1:0]   o_fifo_level;

  modport slave (
    input  i_core_en, i_stall, i_jmp_en, i_ie_catch, i_pc_jmp, i_read_ack, i_instr_mem,
    output o_read_req, o_read_addr, o_instruction, o_pc_fe, o_inc_pc, o_valid,
           o_stall_en_fe, o_fifo_level
  );

  modport master (
    output i_core_en, i_stall, i_jmp_en, i_ie_catch, i_pc_jmp, i_read_ack, i_instr_mem,
    input  o_read_req, o_read_addr, o_instruction, o_pc_fe, o_inc_pc, o_valid,
           o_stall_en_fe, o_fifo_level
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Fetch stage with a prefetch FIFO between instruction memory and decode; redirects flush the buffer.
// Optional macro FETCH_BYPASS_EN lets an ack into an empty FIFO go straight to o_instruction.
module fetch_prefetch #(
  parameter int PC_START_ADDRESS = 0,
  parameter int INSTR_ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH      = 32,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic           i_clk,
  input  logic           i_arst,
  fetch_prefetch_if.slave bus
);
  localparam int PC_WIDTH  = INSTR_ADDR_WIDTH - 2;
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int LVL_WIDTH = PTR_WIDTH + 1;
  localparam logic [PC_WIDTH-1:0]  PC_START = PC_WIDTH'(PC_START_ADDRESS);
  localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, REFILL} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    fetchPc_q, fetchPc_d;
  logic [PTR_WIDTH-1:0]   rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [LVL_WIDTH-1:0]   level_q, level_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pcFe_q, pcFe_d;
  logic                   valid_q, valid_d;

  logic [INSTR_WIDTH-1:0] fifoInstr [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    fifoPc    [FIFO_DEPTH];

  logic redirect, readReq, accept, bypass, push, pop;

  // Interrupt and jump share the single target port, so both collapse into one redirect.
  assign redirect = bus.i_core_en & (bus.i_ie_catch | bus.i_jmp_en);
  assign readReq  = bus.i_core_en & (state_q != IDLE) & (level_q < LVL_FULL) & ~redirect;
  assign accept   = readReq & bus.i_read_ack;
`ifdef FETCH_BYPASS_EN
  assign bypass   = accept & (level_q == '0) & ~bus.i_stall;
`else
  assign bypass   = 1'b0;
`endif
  assign push     = accept & ~bypass;
  assign pop      = bus.i_core_en & ~redirect & ~bus.i_stall & (level_q != '0);

  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    level_d   = level_q;
    instr_d   = instr_q;
    pcFe_d    = pcFe_q;
    valid_d   = valid_q;
    if (!bus.i_core_en) begin
      state_d   = IDLE;
      fetchPc_d = PC_START;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      level_d   = '0;
      instr_d   = '0;
      pcFe_d    = PC_START;
      valid_d   = 1'b0;
    end else if (redirect) begin
      // Redirect wins over stall: the bubble must reach decode even if it is holding.
      state_d   = REFILL;
      fetchPc_d = bus.i_pc_jmp;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      level_d   = '0;
      instr_d   = '0;
      valid_d   = 1'b0;
    end else begin
      if (state_q == IDLE) state_d = RUN;
      else if (state_q == REFILL && accept) state_d = RUN;
      if (accept) fetchPc_d = fetchPc_q + PC_WIDTH'(1);
      if (push) wrPtr_d = wrPtr_q + PTR_WIDTH'(1);
      if (pop) rdPtr_d = rdPtr_q + PTR_WIDTH'(1);
      level_d = level_q + LVL_WIDTH'(push) - LVL_WIDTH'(pop);
      if (!bus.i_stall) begin
        if (bypass) begin
          instr_d = bus.i_instr_mem;
          pcFe_d  = fetchPc_q;
          valid_d = 1'b1;
        end else if (level_q != '0) begin
          instr_d = fifoInstr[rdPtr_q];
          pcFe_d  = fifoPc[rdPtr_q];
          valid_d = 1'b1;
        end else begin
          instr_d = '0;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= IDLE;
      fetchPc_q <= PC_START;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      level_q   <= '0;
      instr_q   <= '0;
      pcFe_q    <= PC_START;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      level_q   <= level_d;
      instr_q   <= instr_d;
      pcFe_q    <= pcFe_d;
      valid_q   <= valid_d;
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers and level.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifoInstr[wrPtr_q] <= bus.i_instr_mem;
      fifoPc[wrPtr_q]    <= fetchPc_q;
    end
  end

  assign bus.o_read_req    = readReq;
  assign bus.o_read_addr   = fetchPc_q;
  assign bus.o_instruction = instr_q;
  assign bus.o_pc_fe       = pcFe_q;
  assign bus.o_inc_pc      = pcFe_q + PC_WIDTH'(1);
  assign bus.o_valid       = valid_q;
  assign bus.o_stall_en_fe = (state_q == REFILL) | redirect;
  assign bus.o_fifo_level  = level_q;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: streaming, stall fill, ack withholding, redirects, PC wrap and disable.
// Memory returns memWord(addr) combinationally; expected values are hand-derived cycle by cycle.
module tb_fetch_prefetch;
  localparam logic [29:0] PC_MAX = 30'h3FFF_FFFF;

  logic clk = 1'b0;
  logic arst;
  int   total = 0;
  int   bad = 0;

  fetch_prefetch_if #(.PC_WIDTH(30), .INSTR_WIDTH(32), .LVL_WIDTH(3)) bus ();

  fetch_prefetch dut (
    .i_clk  (clk),
    .i_arst (arst),
    .bus    (bus.slave)
  );

  // Clock and behavioural instruction memory
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [29:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a};
  endfunction

  assign bus.i_instr_mem = memWord(bus.o_read_addr);

  // Move to the middle of the next cycle, well clear of the active edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reset and idle inputs; leaves the bench mid-cycle right after reset release
  task automatic applyStimulus();
    arst = 1'b1;
    bus.i_core_en = 1'b0; bus.i_stall = 1'b0; bus.i_jmp_en = 1'b0;
    bus.i_ie_catch = 1'b0; bus.i_pc_jmp = '0; bus.i_read_ack = 1'b0;
    tick();
    arst = 1'b0;
    #1;
  endtask

  // Reset values, then asynchronous reset in the middle of a running stream
  task automatic test_reset();
    applyStimulus();
    total++; if (bus.o_instruction !== 32'h0) begin bad++; $display("[TB] FAIL rst_instr got %h want 0", bus.o_instruction); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got %b want 0", bus.o_valid); end
    total++; if (bus.o_pc_fe !== 30'h0) begin bad++; $display("[TB] FAIL rst_pc_fe got %h want 0", bus.o_pc_fe); end
    total++; if (bus.o_inc_pc !== 30'h1) begin bad++; $display("[TB] FAIL rst_inc_pc got %h want 1", bus.o_inc_pc); end
    total++; if (bus.o_fifo_level !== 3'd0) begin bad++; $display("[TB] FAIL rst_level got %0d want 0", bus.o_fifo_level); end
    total++; if (bus.o_read_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_req got %b want 0", bus.o_read_req); end
    total++; if (bus.o_stall_en_fe !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall_en got %b want 0", bus.o_stall_en_fe); end
    bus.i_core_en = 1'b1; bus.i_read_ack = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    total++; if (bus.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL prerst_valid got %b want 1", bus.o_valid); end
    arst = 1'b1;
    #1;
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_valid got %b want 0", bus.o_valid); end
    total++; if (bus.o_fifo_level !== 3'd0) begin bad++; $display("[TB] FAIL midrst_level got %0d want 0", bus.o_fifo_level); end
    total++; if (bus.o_read_req !== 1'b0) begin bad++; $display("[TB] FAIL midrst_req got %b want 0", bus.o_read_req); end
    total++; if (bus.o_read_addr !== 30'h0) begin bad++; $display("[TB] FAIL midrst_addr got %h want 0", bus.o_read_addr); end
    arst = 1'b0;
  endtask

  // Always-ack stream: address k-1 in cycle k, instruction k-3 appears from cycle 3
  task automatic test_stream();
    applyStimulus();
    bus.i_core_en = 1'b1; bus.i_read_ack = 1'b1;
    #1;
    total++; if (bus.o_read_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_req got %b want 0", bus.o_read_req); end
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++; if (bus.o_read_addr !== 30'(k - 1)) begin bad++; $display("[TB] FAIL stream_addr c%0d got %h want %h", k, bus.o_read_addr, k - 1); end
      total++; if (bus.o_read_req !== 1'b1) begin bad++; $display("[TB] FAIL stream_req c%0d got %b want 1", k, bus.o_read_req); end
      total++; if (bus.o_fifo_level !== ((k == 1) ? 3'd0 : 3'd1)) begin bad++; $display("[TB] FAIL stream_level c%0d got %0d", k, bus.o_fifo_level); end
      if (k >= 3) begin
        total++; if (bus.o_instruction !== memWord(30'(k - 3))) begin bad++; $display("[TB] FAIL stream_instr c%0d got %h want %h", k, bus.o_instruction, memWord(30'(k - 3))); end
        total++; if (bus.o_pc_fe !== 30'(k - 3)) begin bad++; $display("[TB] FAIL stream_pc c%0d got %h want %h", k, bus.o_pc_fe, k - 3); end
        total++; if (bus.o_inc_pc !== 30'(k - 2)) begin bad++; $display("[TB] FAIL stream_inc c%0d got %h want %h", k, bus.o_inc_pc, k - 2); end
        total++; if (bus.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid c%0d got %b want 1", k, bus.o_valid); end
      end else begin
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_bubble c%0d got %b want 0", k, bus.o_valid); end
      end
    end
  endtask

  // Stall fills the FIFO to 4 and blocks requests; release issues 0..3 back to back
  task automatic test_stall_fill();
    applyStimulus();
    bus.i_core_en = 1'b1; bus.i_read_ack = 1'b1; bus.i_stall = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      logic [2:0] expLvl;
      tick();
      expLvl = (k - 1 > 4) ? 3'd4 : 3'(k - 1);
      total++; if (bus.o_fifo_level !== expLvl) begin bad++; $display("[TB] FAIL fill_level c%0d got %0d want %0d", k, bus.o_fifo_level, expLvl); end
      total++; if (bus.o_read_req !== (expLvl < 3'd4)) begin bad++; $display("[TB] FAIL fill_req c%0d got %b", k, bus.o_read_req); end
      total++; if (bus.o_valid !== 1'b0 || bus.o_instruction !== 32'h0) begin bad++; $display("[TB] FAIL fill_hold c%0d got %b/%h want 0/0", k, bus.o_valid, bus.o_instruction); end
    end
    bus.i_stall = 1'b0;
    for (int j = 0; j <= 3; j++) begin
      tick();
      total++; if (bus.o_instruction !== memWord(30'(j))) begin bad++; $display("[TB] FAIL drain_instr %0d got %h want %h", j, bus.o_instruction, memWord(30'(j))); end
      total++; if (bus.o_pc_fe !== 30'(j) || bus.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL drain_pc %0d got %h/%b want %h/1", j, bus.o_pc_fe, bus.o_valid, j); end
      total++; if (bus.o_fifo_level !== 3'd3) begin bad++; $display("[TB] FAIL drain_level %0d got %0d want 3", j, bus.o_fifo_level); end
    end
  endtask

  // Ack withheld for three cycles on address 5: request held, FIFO drains to bubbles
  task automatic test_ack_hold();
    applyStimulus();
    bus.i_core_en = 1'b1; bus.i_read_ack = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    tick();
    bus.i_read_ack = 1'b0;
    total++; if (bus.o_read_addr !== 30'd5 || bus.o_read_req !== 1'b1) begin bad++; $display("[TB] FAIL hold_addr c6 got %h/%b want 5/1", bus.o_read_addr, bus.o_read_req); end
    total++; if (bus.o_instruction !== memWord(30'd3) || bus.o_fifo_level !== 3'd1) begin bad++; $display("[TB] FAIL hold_out c6 got %h/%0d", bus.o_instruction, bus.o_fifo_level); end
    tick();
    total++; if (bus.o_read_addr !== 30'd5 || bus.o_read_req !== 1'b1) begin bad++; $display("[TB] FAIL hold_addr c7 got %h/%b want 5/1", bus.o_read_addr, bus.o_read_req); end
    total++; if (bus.o_instruction !== memWord(30'd4) || bus.o_fifo_level !== 3'd0) begin bad++; $display("[TB] FAIL hold_out c7 got %h/%0d", bus.o_instruction, bus.o_fifo_level); end
    tick();
    total++; if (bus.o_read_addr !== 30'd5 || bus.o_read_req !== 1'b1) begin bad++; $display("[TB] FAIL hold_addr c8 got %h/%b want 5/1", bus.o_read_addr, bus.o_read_req); end
    total++; if (bus.o_instruction !== 32'h0 || bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_bubble c8 got %h/%b want 0/0", bus.o_instruction, bus.o_valid); end
    total++; if (bus.o_pc_fe !== 30'd4) begin bad++; $display("[TB] FAIL hold_pc c8 got %h want 4", bus.o_pc_fe); end
    tick();
    bus.i_read_ack = 1'b1;
    total++; if (bus.o_read_addr !== 30'd5 || bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL hold_addr c9 got %h/%b want 5/0", bus.o_read_addr, bus.o_valid); end
    tick();
    total++; if (bus.o_fifo_level !== 3'd1 || bus.o_read_addr !== 30'd6) begin bad++; $display("[TB] FAIL resume c10 got %0d/%h want 1/6", bus.o_fifo_level, bus.o_read_addr); end
    tick();
    total++; if (bus.o_instruction !== memWord(30'd5) || bus.o_pc_fe !== 30'd5) begin bad++; $display("[TB] FAIL resume c11 got %h/%h", bus.o_instruction, bus.o_pc_fe); end
  endtask

  // Jump to 0x40 at level 3 with a same-cycle ack; refill stall until 0x40 is acked
  task automatic test_jump();
    applyStimulus();
    bus.i_core_en = 1'b1; bus.i_read_ack = 1'b1; bus.i_stall = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    total++; if (bus.o_fifo_level !== 3'd3) begin bad++; $display("[TB] FAIL jmp_prelevel got %0d want 3", bus.o_fifo_level); end
    bus.i_jmp_en = 1'b1; bus.i_pc_jmp = 30'h40;
    #1;
    total++; if (bus.o_read_req !== 1'b0 || bus.o_stall_en_fe !== 1'b1) begin bad++; $display("[TB] FAIL jmp_cycle got req=%b stall=%b want 0/1", bus.o_read_req, bus.o_stall_en_fe); end
    tick();
    bus.i_jmp_en = 1'b0; bus.i_stall = 1'b0; bus.i_read_ack = 1'b0;
    #1;
    total++; if (bus.o_fifo_level !== 3'd0 || bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL jmp_flush got %0d/%b want 0/0", bus.o_fifo_level, bus.o_valid); end
    total++; if (bus.o_read_addr !== 30'h40 || bus.o_stall_en_fe !== 1'b1) begin bad++; $display("[TB] FAIL jmp_target got %h/%b want 40/1", bus.o_read_addr, bus.o_stall_en_fe); end
    tick();
    bus.i_read_ack = 1'b1;
    total++; if (bus.o_read_addr !== 30'h40 || bus.o_stall_en_fe !== 1'b1) begin bad++; $display("[TB] FAIL jmp_wait got %h/%b want 40/1", bus.o_read_addr, bus.o_stall_en_fe); end
    tick();
    total++; if (bus.o_stall_en_fe !== 1'b0 || bus.o_fifo_level !== 3'd1 || bus.o_read_addr !== 30'h41) begin bad++; $display("[TB] FAIL jmp_run got %b/%0d/%h want 0/1/41", bus.o_stall_en_fe, bus.o_fifo_level, bus.o_read_addr); end
    tick();
    total++; if (bus.o_pc_fe !== 30'h40 || bus.o_instruction !== memWord(30'h40) || bus.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL jmp_first got %h/%h/%b want 40", bus.o_pc_fe, bus.o_instruction, bus.o_valid); end
  endtask

  // Interrupt and jump together under stall: bubble next cycle, fetch resumes at 0x10
  task automatic test_ie_jmp_together();
    applyStimulus();
    bus.i_core_en = 1'b1; bus.i_read_ack = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    total++; if (bus.o_valid !== 1'b1) begin bad++; $display("[TB] FAIL ie_pre got %b want 1", bus.o_valid); end
    bus.i_stall = 1'b1; bus.i_ie_catch = 1'b1; bus.i_jmp_en = 1'b1; bus.i_pc_jmp = 30'h10;
    #1;
    total++; if (bus.o_stall_en_fe !== 1'b1 || bus.o_read_req !== 1'b0) begin bad++; $display("[TB] FAIL ie_cycle got %b/%b want 1/0", bus.o_stall_en_fe, bus.o_read_req); end
    tick();
    bus.i_ie_catch = 1'b0; bus.i_jmp_en = 1'b0; bus.i_stall = 1'b0;
    #1;
    total++; if (bus.o_instruction !== 32'h0 || bus.o_valid !== 1'b0) begin bad++; $display("[TB] FAIL ie_bubble got %h/%b want 0/0", bus.o_instruction, bus.o_valid); end
    total++; if (bus.o_read_addr !== 30'h10 || bus.o_fifo_level !== 3'd0) begin bad++; $display("[TB] FAIL ie_target got %h/%0d want 10/0", bus.o_read_addr, bus.o_fifo_level); end
    tick();
    total++; if (bus.o_fifo_level !== 3'd1 || bus.o_stall_en_fe !== 1'b0) begin bad++; $display("[TB] FAIL ie_refill got %0d/%b want 1/0", bus.o_fifo_level, bus.o_stall_en_fe); end
    tick();
    total++; if (bus.o_pc_fe !== 30'h10 || bus.o_inc_pc !== 30'h11 || bus.o_instruction !== memWord(30'h10)) begin bad++; $display("[TB] FAIL ie_first got %h/%h/%h", bus.o_pc_fe, bus.o_inc_pc, bus.o_instruction); end
  endtask

  // Fetch PC wraps at the top of the address space, then core disable returns to start
  task automatic test_wrap_disable();
    applyStimulus();
    bus.i_core_en = 1'b1; bus.i_read_ack = 1'b1;
    tick();
    bus.i_jmp_en = 1'b1; bus.i_pc_jmp = PC_MAX;
    tick();
    bus.i_jmp_en = 1'b0;
    #1;
    total++; if (bus.o_read_addr !== PC_MAX || bus.o_read_req !== 1'b1) begin bad++; $display("[TB] FAIL wrap_max got %h/%b", bus.o_read_addr, bus.o_read_req); end
    tick();
    total++; if (bus.o_read_addr !== 30'h0) begin bad++; $display("[TB] FAIL wrap_addr got %h want 0", bus.o_read_addr); end
    tick();
    total++; if (bus.o_pc_fe !== PC_MAX || bus.o_inc_pc !== 30'h0 || bus.o_instruction !== memWord(PC_MAX)) begin bad++; $display("[TB] FAIL wrap_out got %h/%h/%h", bus.o_pc_fe, bus.o_inc_pc, bus.o_instruction); end
    tick();
    total++; if (bus.o_pc_fe !== 30'h0 || bus.o_instruction !== memWord(30'h0)) begin bad++; $display("[TB] FAIL wrap_next got %h/%h", bus.o_pc_fe, bus.o_instruction); end
    bus.i_core_en = 1'b0;
    #1;
    total++; if (bus.o_read_req !== 1'b0) begin bad++; $display("[TB] FAIL dis_req got %b want 0", bus.o_read_req); end
    tick();
    total++; if (bus.o_fifo_level !== 3'd0 || bus.o_pc_fe !== 30'h0 || bus.o_valid !== 1'b0 || bus.o_instruction !== 32'h0) begin bad++; $display("[TB] FAIL dis_state got %0d/%h/%b/%h", bus.o_fifo_level, bus.o_pc_fe, bus.o_valid, bus.o_instruction); end
    total++; if (bus.o_read_req !== 1'b0 || bus.o_stall_en_fe !== 1'b0) begin bad++; $display("[TB] FAIL dis_ctrl got %b/%b want 0/0", bus.o_read_req, bus.o_stall_en_fe); end
    bus.i_core_en = 1'b1;
    tick();
    total++; if (bus.o_read_addr !== 30'h0 || bus.o_read_req !== 1'b1) begin bad++; $display("[TB] FAIL reen got %h/%b want 0/1", bus.o_read_addr, bus.o_read_req); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_ack_hold();
    test_jump();
    test_ie_jmp_together();
    test_wrap_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
